// File: rtl/clip_tri_sequencer.sv
// Sequencer between the triangle clipper and triangle setup: starts one clip per request,
// captures the 1- or 2-triangle bundle and streams it out one triangle at a time.
module clip_tri_sequencer #(
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic                  clip_start_o,
    input  logic                  clip_done_i,
    input  logic                  clip_valid_i,
    input  logic [1:0]            clip_num_tri_i,
    input  logic [24*WIDTH-1:0]   clip_verts_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [12*WIDTH-1:0]   out_tri_o,
    output logic                  out_last_o,
    output logic [CNT_W-1:0]      tri_cnt_o,
    output logic [CNT_W-1:0]      cull_cnt_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        EMIT0     = 2'd2,
        EMIT1     = 2'd3
    } state_t;

    localparam int TRI_W = 12 * WIDTH;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             r_state;
    state_t             w_next;
    logic               r_clip_start;
    logic               r_out_valid;
    logic               r_out_last;
    logic [TRI_W-1:0]   r_out_tri;
    logic [TRI_W-1:0]   r_tri1;
    logic [WD_W-1:0]    r_wdog;
    logic [CNT_W-1:0]   r_tri_cnt;
    logic [CNT_W-1:0]   r_cull_cnt;
    logic               r_timeout;

    logic               w_req_ready;
    logic               w_capture;
    logic               w_cull;
    logic               w_timeout_hit;
    logic               w_tri_hs;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        w_next        = r_state;
        w_req_ready   = 1'b0;
        w_capture     = 1'b0;
        w_cull        = 1'b0;
        w_timeout_hit = 1'b0;
        w_tri_hs      = 1'b0;
        case (r_state)
            IDLE: begin
                // A done still high belongs to the previous clip; wait for the clipper to go idle.
                if (req_valid_i && !clip_done_i)
                    w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (clip_done_i) begin
                    w_req_ready = 1'b1;
                    w_capture   = 1'b1;
                    if (!clip_valid_i || (clip_num_tri_i == 2'd0)) begin
                        w_cull = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_next = EMIT0;
                    end
                end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                    w_req_ready   = 1'b1;
                    w_timeout_hit = 1'b1;
                    w_next        = IDLE;
                end
            end
            EMIT0: begin
                if (out_ready_i) begin
                    w_tri_hs = 1'b1;
                    w_next   = r_out_last ? IDLE : EMIT1;
                end
            end
            EMIT1: begin
                if (out_ready_i) begin
                    w_tri_hs = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_clip_start <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_clip_start <= (w_next == WAIT_DONE);
            r_out_valid  <= (w_next == EMIT0) || (w_next == EMIT1);
        end
    end

    // NOTE: the bundle registers are reset too, so out_tri_o reads zero after reset rather than stale data.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_out_tri  <= '0;
            r_tri1     <= '0;
            r_out_last <= 1'b0;
            r_wdog     <= '0;
            r_tri_cnt  <= '0;
            r_cull_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wdog <= (r_state == WAIT_DONE) ? r_wdog + WD_W'(1) : '0;
            if (w_capture && !w_cull) begin
                r_out_tri  <= clip_verts_i[24*WIDTH-1 -: TRI_W];
                r_tri1     <= clip_verts_i[TRI_W-1:0];
                // Illegal count 3 is handled as a single triangle.
                r_out_last <= (clip_num_tri_i != 2'd2);
            end else if (w_tri_hs && (r_state == EMIT0) && !r_out_last) begin
                r_out_tri  <= r_tri1;
                r_out_last <= 1'b1;
            end
            if (w_cull)
                r_cull_cnt <= r_cull_cnt + CNT_W'(1);
            if (w_tri_hs)
                r_tri_cnt <= r_tri_cnt + CNT_W'(1);
            if (w_timeout_hit)
                r_timeout <= 1'b1;
        end
    end

    assign req_ready_o  = w_req_ready;
    assign clip_start_o = r_clip_start;
    assign out_valid_o  = r_out_valid;
    assign out_tri_o    = r_out_tri;
    assign out_last_o   = r_out_last;
    assign tri_cnt_o    = r_tri_cnt;
    assign cull_cnt_o   = r_cull_cnt;
    assign timeout_o    = r_timeout;

endmodule
